sdram_port_arbiter: RTL
=======================

# sdram_port_arbiter

Two-requester arbiter sharing one SDRAM controller Avalon-MM slave (one of the board's two SDRAM channels). Each requester sees a private single-beat Avalon-MM slave port; the arbiter registers one command at a time toward the controller and routes pipelined read data back to the issuing port via an in-order tag FIFO. One instance sits in front of each SDRAM controller in the system.

## Interface
Parameters:
- ADDR_W, 22, word address width (matches controller slave)
- DATA_W, 16, data width; byteenable width DATA_W/8
- MAX_PEND, 4, max outstanding reads (tag FIFO depth, power of two, 2..16)

Ports:
- clk  in  1  system clock (50 MHz domain)
- reset_n  in  1  synchronous, active-low reset
- m0_address / m1_address  in  ADDR_W  requester word address
- m0_read, m0_write / m1_read, m1_write  in  1  command strobes (never both high on one port)
- m0_writedata / m1_writedata  in  DATA_W  write data
- m0_byteenable / m1_byteenable  in  DATA_W/8  byte lanes
- m0_waitrequest / m1_waitrequest  out  1  low only in the cycle that port's command is captured
- m0_readdata / m1_readdata  out  DATA_W  returned read data
- m0_readdatavalid / m1_readdatavalid  out  1  read data valid, one port at a time
- s_address  out  ADDR_W; s_read, s_write  out  1; s_writedata  out  DATA_W; s_byteenable  out  DATA_W/8  command to controller
- s_waitrequest  in  1  controller stall
- s_readdata  in  DATA_W; s_readdatavalid  in  1  controller read return

## Operation
- Command register (CR): holds one command; valid when s_read|s_write high. Emptied on cycle with (s_read|s_write) & !s_waitrequest.
- Capture allowed when CR empty or emptying this cycle, and, for a read, pend_cnt < MAX_PEND (pend_cnt counts reads captured but not yet returned).
- Arbitration among ports with read|write high: round-robin; last_grant register; on contention grant port != last_grant; single requester always granted. last_grant resets to 1 (port 0 wins first tie).
- On capture: CR <= port's address/data/byteenable/strobes; granted port's waitrequest = 0 that cycle (combinational); last_grant <= port; if read, push port id into tag FIFO, pend_cnt++.
- Return: on s_readdatavalid with FIFO non-empty, pop head; next cycle assert readdatavalid on head port, readdata = registered s_readdata on both ports. pend_cnt--.
- Simultaneous push and pop: pend_cnt unchanged, FIFO contents correct.
- s_readdatavalid with empty FIFO: ignored, no port valid.
- Blocked read (pend_cnt full) does not block a write on the other port in the same cycle; arbiter grants the eligible port.

## Timing
- Reset values: s_read=s_write=0, s_address/s_writedata=0, s_byteenable=0, m*_readdatavalid=0, m*_readdata=0, pend_cnt=0, FIFO empty, last_grant=1; m*_waitrequest=1 while reset_n low.
- Command latency: requester capture cycle N -> s_read/s_write high from N+1.
- Back-to-back: with s_waitrequest=0, one command per cycle sustained (alternating under contention).
- Read return latency: s_readdatavalid cycle K -> m*_readdatavalid cycle K+1.
- CR contents stable while s_waitrequest=1.
- Reset mid-operation: all state cleared next edge; in-flight controller returns after reset see empty FIFO and are dropped.

## Configuration
- SDRAM_ARB_FIXED_PRIO_EN defined: port 0 always wins contention; last_grant unused. Undefined: round-robin as above.

## Test plan
- Single port 0 write addr 0x000010 data 0xBEEF, s_waitrequest=0 -> s_write high exactly one cycle with those values, m0_waitrequest low one cycle.
- Both ports read continuously, s_waitrequest=0 -> grants alternate 0,1,0,1; returns with data 0x1111,0x2222,... appear on m0,m1,m0,m1 valid one cycle after s_readdatavalid.
- Hold s_waitrequest=1 for 5 cycles with CR holding a write -> s_* outputs stable, both m*_waitrequest high, capture resumes cycle after release.
- Issue 4 reads with no returns (MAX_PEND=4) -> 5th read stalled; port 1 write still captured; one return releases the read next cycle.
- Assert reset_n=0 with 3 reads outstanding, then 3 s_readdatavalid pulses -> no m*_readdatavalid, all outputs at reset values.
- With SDRAM_ARB_FIXED_PRIO_EN, both ports request continuously -> port 0 granted every cycle, port 1 only when port 0 idle.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// rtl/sdram_port_arbiter.sv - two-port Avalon-MM arbiter in front of one SDRAM controller slave
// Build option: SDRAM_ARB_FIXED_PRIO_EN gives port 0 fixed priority instead of round-robin.
module sdram_port_arbiter #(
    parameter int ADDR_W   = 22,
    parameter int DATA_W   = 16,
    parameter int MAX_PEND = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [ADDR_W-1:0]   m0_address,
    input  logic                m0_read,
    input  logic                m0_write,
    input  logic [DATA_W-1:0]   m0_writedata,
    input  logic [DATA_W/8-1:0] m0_byteenable,
    output logic                m0_waitrequest,
    output logic [DATA_W-1:0]   m0_readdata,
    output logic                m0_readdatavalid,
    input  logic [ADDR_W-1:0]   m1_address,
    input  logic                m1_read,
    input  logic                m1_write,
    input  logic [DATA_W-1:0]   m1_writedata,
    input  logic [DATA_W/8-1:0] m1_byteenable,
    output logic                m1_waitrequest,
    output logic [DATA_W-1:0]   m1_readdata,
    output logic                m1_readdatavalid,
    output logic [ADDR_W-1:0]   s_address,
    output logic                s_read,
    output logic                s_write,
    output logic [DATA_W-1:0]   s_writedata,
    output logic [DATA_W/8-1:0] s_byteenable,
    input  logic                s_waitrequest,
    input  logic [DATA_W-1:0]   s_readdata,
    input  logic                s_readdatavalid
);

    localparam int BE_W  = DATA_W / 8;
    localparam int PTR_W = (MAX_PEND > 1) ? $clog2(MAX_PEND) : 1;
    localparam int CNT_W = $clog2(MAX_PEND + 1);

    logic [ADDR_W-1:0] r_s_address;
    logic              r_s_read;
    logic              r_s_write;
    logic [DATA_W-1:0] r_s_writedata;
    logic [BE_W-1:0]   r_s_byteenable;

    logic [MAX_PEND-1:0] r_tag;
    logic [PTR_W-1:0]    r_wr_ptr;
    logic [PTR_W-1:0]    r_rd_ptr;
    logic [CNT_W-1:0]    r_pend_cnt;

    logic              r_rdv0;
    logic              r_rdv1;
    logic [DATA_W-1:0] r_readdata;

    logic              w_cr_free;
    logic              w_rd_ok;
    logic              w_elig0;
    logic              w_elig1;
    logic              w_grant;
    logic              w_capture;
    logic              w_push;
    logic              w_pop;
    logic              w_head;
    logic [ADDR_W-1:0] w_sel_address;
    logic              w_sel_read;
    logic              w_sel_write;
    logic [DATA_W-1:0] w_sel_writedata;
    logic [BE_W-1:0]   w_sel_byteenable;

    // The command register may be refilled in the same cycle the controller takes it.
    assign w_cr_free = !(r_s_read | r_s_write) | !s_waitrequest;
    assign w_rd_ok   = r_pend_cnt < CNT_W'(MAX_PEND);
    assign w_elig0   = m0_write | (m0_read & w_rd_ok);
    assign w_elig1   = m1_write | (m1_read & w_rd_ok);

`ifdef SDRAM_ARB_FIXED_PRIO_EN
    assign w_grant = !w_elig0;
`else
    logic r_last_grant;

    assign w_grant = (w_elig0 & w_elig1) ? !r_last_grant : w_elig1;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_last_grant <= 1'b1;
        end else if (w_capture) begin
            r_last_grant <= w_grant;
        end
    end
`endif

    assign w_capture      = reset_n & w_cr_free & (w_elig0 | w_elig1);
    assign m0_waitrequest = !(w_capture & !w_grant);
    assign m1_waitrequest = !(w_capture & w_grant);

    assign w_sel_address    = w_grant ? m1_address    : m0_address;
    assign w_sel_read       = w_grant ? m1_read       : m0_read;
    assign w_sel_write      = w_grant ? m1_write      : m0_write;
    assign w_sel_writedata  = w_grant ? m1_writedata  : m0_writedata;
    assign w_sel_byteenable = w_grant ? m1_byteenable : m0_byteenable;

    assign w_push = w_capture & w_sel_read;
    assign w_pop  = s_readdatavalid & (r_pend_cnt != '0);
    assign w_head = r_tag[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_s_address    <= '0;
            r_s_read       <= 1'b0;
            r_s_write      <= 1'b0;
            r_s_writedata  <= '0;
            r_s_byteenable <= '0;
        end else if (w_capture) begin
            r_s_address    <= w_sel_address;
            r_s_read       <= w_sel_read;
            r_s_write      <= w_sel_write;
            r_s_writedata  <= w_sel_writedata;
            r_s_byteenable <= w_sel_byteenable;
        end else if (w_cr_free) begin
            r_s_read  <= 1'b0;
            r_s_write <= 1'b0;
        end
    end

    // Tag FIFO: one bit per outstanding read naming the port that issued it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_tag[r_wr_ptr] <= w_grant;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pend_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_pend_cnt <= r_pend_cnt + CNT_W'(1);
                2'b01:   r_pend_cnt <= r_pend_cnt - CNT_W'(1);
                default: r_pend_cnt <= r_pend_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rdv0     <= 1'b0;
            r_rdv1     <= 1'b0;
            r_readdata <= '0;
        end else begin
            r_rdv0 <= w_pop & !w_head;
            r_rdv1 <= w_pop & w_head;
            if (w_pop) begin
                r_readdata <= s_readdata;
            end
        end
    end

    assign s_address        = r_s_address;
    assign s_read           = r_s_read;
    assign s_write          = r_s_write;
    assign s_writedata      = r_s_writedata;
    assign s_byteenable     = r_s_byteenable;
    assign m0_readdata      = r_readdata;
    assign m1_readdata      = r_readdata;
    assign m0_readdatavalid = r_rdv0;
    assign m1_readdatavalid = r_rdv1;

endmodule
